vx_imadd_rs: RTL

- Multi-lane pipelined integer multiply-shift-add unit for the ALU/DSP path: per lane computes ((a*b + rnd) >> shift) ± c.
- Generational successor to the plain multiply-shift-add unit. Adds per-request rounding, subtract, saturation, lane masking, per-lane saturation flags, configurable multiplier latency and an in-flight occupancy counter.
- Sits between the issue/dispatch stage and the commit arbiter, using valid/ready handshakes on both sides.

---
 rtl/vx_imadd_rs.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vx_imadd_rs.sv
// vx_imadd_rs -- multi-lane pipelined integer multiply / round / shift / add-sub /
// saturate unit. Each lane computes ((a*b + rnd) >> shift) +/- c. The datapath is
// LATENCY multiplier stages (M), one shift/add/saturate stage (S) and a 2-entry
// output skid buffer (O). Valid/ready handshakes on both sides, strict FIFO order,
// and a counter of accepted-but-undelivered requests.

module vx_imadd_rs #(
  parameter int NUM_LANES   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_SHIFT   = 31,
  parameter int SIGNED      = 1,
  parameter int LATENCY     = 3,
  parameter int TAG_WIDTH   = 8,
  parameter int SHIFT_WIDTH = $clog2(MAX_SHIFT + 1),
  parameter int CNT_WIDTH   = $clog2(LATENCY + 4)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic [SHIFT_WIDTH-1:0]          shift_in,
  input  logic                            rnd_in,
  input  logic                            sub_in,
  input  logic                            sat_in,
  input  logic [NUM_LANES-1:0]            mask_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data1_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data2_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data3_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic [NUM_LANES-1:0]            sat_flag_out,
  output logic [TAG_WIDTH-1:0]            tag_out,
  output logic [CNT_WIDTH-1:0]            pending_out
);

  // Full product width, rounded-product width is PW+1, add/sub result width is RW.
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 2;
  localparam int BW = NUM_LANES * DATA_WIDTH;

  // Saturation bounds expressed in the wide signed result domain.
  localparam logic signed [RW-1:0] SAT_SMAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_SMIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0] SAT_UMAX = {{(RW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  // Values substituted for a lane whose result was clamped high or low.
  localparam logic [DATA_WIDTH-1:0] CLAMP_HI = (SIGNED != 0) ?
    {1'b0, {(DATA_WIDTH-1){1'b1}}} : {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] CLAMP_LO = (SIGNED != 0) ?
    {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

  // Per-request control fields that ride alongside the multiplier pipeline.
  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   rnd;
    logic                   sub;
    logic                   sat;
    logic [NUM_LANES-1:0]   mask;
    logic [BW-1:0]          c;
    logic [TAG_WIDTH-1:0]   tag;
  } ctrl_t;

  // Operand extension to the product width; sign- or zero-extension picks the
  // multiply flavour, since the low PW bits of a PW x PW product are then exact.
  function automatic logic [PW-1:0] extOp(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED != 0) extOp = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
    else             extOp = {{DATA_WIDTH{1'b0}}, x};
  endfunction

  // Stage M registers.
  logic [LATENCY-1:0]                  mValid_q;
  logic [NUM_LANES-1:0][PW-1:0]        mProd_q [LATENCY];
  ctrl_t                               mCtrl_q [LATENCY];
  logic [NUM_LANES-1:0][PW-1:0]        mProd_d;
  ctrl_t                               mCtrl_d;

  // Stage S registers.
  logic                                sValid_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] sData_q;
  logic [NUM_LANES-1:0]                sFlag_q;
  logic [TAG_WIDTH-1:0]                sTag_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] sData_d;
  logic [NUM_LANES-1:0]                sFlag_d;

  // Stage O: output entry (drives the ports) and spare entry.
  logic                                outValid_q, outValid_d;
  logic [BW-1:0]                       outData_q, outData_d;
  logic [NUM_LANES-1:0]                outFlag_q, outFlag_d;
  logic [TAG_WIDTH-1:0]                outTag_q, outTag_d;
  logic                                spareValid_q, spareValid_d;
  logic [BW-1:0]                       spareData_q, spareData_d;
  logic [NUM_LANES-1:0]                spareFlag_q, spareFlag_d;
  logic [TAG_WIDTH-1:0]                spareTag_q, spareTag_d;

  // In-flight counter.
  logic [CNT_WIDTH-1:0]                pendCnt_q, pendCnt_d;

  // Handshake / enable network.
  logic mLastValid, skidReady, sReady, mEnable, accept, deliver, push;

  // Per-lane arithmetic temporaries for stage S.
  logic [PW:0]            laneP, laneRndAdd, laneRnd, laneT;
  logic [DATA_WIDTH-1:0]  laneC;
  logic signed [RW-1:0]   laneTExt, laneCExt, laneR;
  logic                   laneHi, laneLo;

  assign mLastValid = mValid_q[LATENCY-1];
  assign skidReady  = ~spareValid_q;
  assign sReady     = ~sValid_q | skidReady;
  assign mEnable    = ~mLastValid | sReady;
  assign ready_in   = mEnable;
  assign accept     = valid_in & mEnable;
  assign deliver    = outValid_q & ready_out;
  assign push       = sValid_q & skidReady;

  // Form the per-lane products and bundle the request's control fields for stage M.
  always_comb begin
    mProd_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      mProd_d[l] = extOp(data1_in[l*DATA_WIDTH +: DATA_WIDTH]) *
                   extOp(data2_in[l*DATA_WIDTH +: DATA_WIDTH]);
    end
    mCtrl_d.shift = shift_in;
    mCtrl_d.rnd   = rnd_in;
    mCtrl_d.sub   = sub_in;
    mCtrl_d.sat   = sat_in;
    mCtrl_d.mask  = mask_in;
    mCtrl_d.c     = data3_in;
    mCtrl_d.tag   = tag_in;
  end

  // Multiplier chain: all LATENCY stages advance together or stall together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mValid_q <= '0;
    end else if (mEnable) begin
      mValid_q[0] <= accept;
      mProd_q[0]  <= mProd_d;
      mCtrl_q[0]  <= mCtrl_d;
      for (int i = 1; i < LATENCY; i++) begin
        mValid_q[i] <= mValid_q[i-1];
        mProd_q[i]  <= mProd_q[i-1];
        mCtrl_q[i]  <= mCtrl_q[i-1];
      end
    end
  end

  // Round, shift, add/subtract c, then saturate or truncate, lane by lane.
  always_comb begin
    sData_d    = '0;
    sFlag_d    = '0;
    laneP      = '0;
    laneRndAdd = '0;
    laneRnd    = '0;
    laneT      = '0;
    laneC      = '0;
    laneTExt   = '0;
    laneCExt   = '0;
    laneR      = '0;
    laneHi     = 1'b0;
    laneLo     = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (SIGNED != 0) laneP = {mProd_q[LATENCY-1][l][PW-1], mProd_q[LATENCY-1][l]};
      else             laneP = {1'b0, mProd_q[LATENCY-1][l]};

      if (mCtrl_q[LATENCY-1].rnd && (mCtrl_q[LATENCY-1].shift != '0))
        laneRndAdd = (PW+1)'(1) << (mCtrl_q[LATENCY-1].shift - SHIFT_WIDTH'(1));
      else
        laneRndAdd = '0;
      laneRnd = laneP + laneRndAdd;

      if (SIGNED != 0) laneT = $unsigned($signed(laneRnd) >>> mCtrl_q[LATENCY-1].shift);
      else             laneT = laneRnd >> mCtrl_q[LATENCY-1].shift;

      laneC = mCtrl_q[LATENCY-1].c[l*DATA_WIDTH +: DATA_WIDTH];
      if (SIGNED != 0) begin
        laneTExt = {laneT[PW], laneT};
        laneCExt = {{(RW-DATA_WIDTH){laneC[DATA_WIDTH-1]}}, laneC};
      end else begin
        laneTExt = {1'b0, laneT};
        laneCExt = {{(RW-DATA_WIDTH){1'b0}}, laneC};
      end

      if (mCtrl_q[LATENCY-1].sub) laneR = laneTExt - laneCExt;
      else                        laneR = laneTExt + laneCExt;

      if (SIGNED != 0) begin
        laneHi = laneR > SAT_SMAX;
        laneLo = laneR < SAT_SMIN;
      end else begin
        laneHi = laneR > SAT_UMAX;
        laneLo = laneR[RW-1];
      end

      if (!mCtrl_q[LATENCY-1].mask[l]) begin
        sData_d[l] = '0;
        sFlag_d[l] = 1'b0;
      end else if (mCtrl_q[LATENCY-1].sat && laneHi) begin
        sData_d[l] = CLAMP_HI;
        sFlag_d[l] = 1'b1;
      end else if (mCtrl_q[LATENCY-1].sat && laneLo) begin
        sData_d[l] = CLAMP_LO;
        sFlag_d[l] = 1'b1;
      end else begin
        sData_d[l] = laneR[DATA_WIDTH-1:0];
        sFlag_d[l] = 1'b0;
      end
    end
  end

  // Stage S register: captures the last multiplier stage whenever it has room.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sValid_q <= 1'b0;
    end else if (sReady) begin
      sValid_q <= mLastValid;
      sData_q  <= sData_d;
      sFlag_q  <= sFlag_d;
      sTag_q   <= mCtrl_q[LATENCY-1].tag;
    end
  end

  // Skid buffer next state: the spare entry absorbs one result when the consumer stalls.
  always_comb begin
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    outFlag_d    = outFlag_q;
    outTag_d     = outTag_q;
    spareValid_d = spareValid_q;
    spareData_d  = spareData_q;
    spareFlag_d  = spareFlag_q;
    spareTag_d   = spareTag_q;
    if (spareValid_q) begin
      if (deliver) begin
        outData_d    = spareData_q;
        outFlag_d    = spareFlag_q;
        outTag_d     = spareTag_q;
        spareValid_d = 1'b0;
      end
    end else if (push && (!outValid_q || deliver)) begin
      outValid_d = 1'b1;
      outData_d  = sData_q;
      outFlag_d  = sFlag_q;
      outTag_d   = sTag_q;
    end else if (push) begin
      spareValid_d = 1'b1;
      spareData_d  = sData_q;
      spareFlag_d  = sFlag_q;
      spareTag_d   = sTag_q;
    end else if (deliver) begin
      outValid_d = 1'b0;
    end
  end

  // Skid buffer registers; the output entry drives the ports directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outFlag_q    <= '0;
      outTag_q     <= '0;
      spareValid_q <= 1'b0;
      spareData_q  <= '0;
      spareFlag_q  <= '0;
      spareTag_q   <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outFlag_q    <= outFlag_d;
      outTag_q     <= outTag_d;
      spareValid_q <= spareValid_d;
      spareData_q  <= spareData_d;
      spareFlag_q  <= spareFlag_d;
      spareTag_q   <= spareTag_d;
    end
  end

  // Occupancy next state: up on accept, down on delivery, unchanged on both.
  always_comb begin
    pendCnt_d = pendCnt_q;
    if (accept && !deliver)      pendCnt_d = pendCnt_q + CNT_WIDTH'(1);
    else if (!accept && deliver) pendCnt_d = pendCnt_q - CNT_WIDTH'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!reset_n) pendCnt_q <= '0;
    else          pendCnt_q <= pendCnt_d;
  end

  assign valid_out    = outValid_q;
  assign data_out     = outData_q;
  assign sat_flag_out = outFlag_q;
  assign tag_out      = outTag_q;
  assign pending_out  = pendCnt_q;

  // Shift amounts beyond MAX_SHIFT are not supported.
  shiftLegal: assert property (@(posedge clk) disable iff (!reset_n)
    accept |-> (shift_in <= SHIFT_WIDTH'(MAX_SHIFT)));

  // The pipeline holds at most LATENCY+3 requests.
  pendBound: assert property (@(posedge clk) disable iff (!reset_n)
    pendCnt_q <= CNT_WIDTH'(LATENCY + 3));

  // A delivery with nothing outstanding would underflow the counter.
  pendUnderflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(deliver && !accept && (pendCnt_q == '0)));

  // An accept with the pipeline already full would overflow the counter.
  pendOverflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(accept && !deliver && (pendCnt_q == CNT_WIDTH'(LATENCY + 3))));

endmodule
